// File: rtl/hash_pkg.sv
// Shared definitions for the fullHash message feeder, the hash core and their benches.
package hash_pkg;

  localparam int HASH_LEN_W = 64;
  localparam int HASH_DIG_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/hash_msg_buf.sv
// DEPTH x 8 message buffer: one write port, one read port with registered data.
// A read of the address being written in the same cycle returns the new byte.
module hash_msg_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read data returns to zero whenever no read is requested, so it can drive M directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/hash_msg_feeder.sv
// Buffers an upstream byte message, replays it into fullHash as one burst and
// hands the digest downstream. Optional WAIT timeout: HASH_FEEDER_TIMEOUT_EN.
module hash_msg_feeder
  import hash_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DIG_W   = HASH_DIG_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  M_valid,
  output logic [7:0]            M,
  output logic [HASH_LEN_W-1:0] C_in,
  input  logic                  hash_ready,
  input  logic [DIG_W-1:0]      digest,
  output logic                  dig_valid,
  input  logic                  dig_ready,
  output logic [DIG_W-1:0]      dig_data,
  output logic                  err_ovf,
  output logic                  err_tmo,
  output logic                  busy,
  output feeder_state_t         fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

  feeder_state_t state_q, state_d;
  logic [LW-1:0] len_q, len_d, rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          in_hs, dig_hs, tmo_hit;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  assign in_hs     = in_valid & in_ready;
  assign dig_hs    = dig_valid & dig_ready;
  assign err_ovf   = ovf_q;
  assign fsm_state = state_q;
  assign rd_en     = (state_d == ST_SEND);

  hash_msg_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (M)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    wr_addr  = len_q[AW-1:0];
    rd_addr  = '0;
    case (state_q)
      ST_IDLE: if (in_hs) begin
        wr_en    = 1'b1;
        wr_addr  = '0;
        len_d    = LW'(1);
        rd_ptr_d = '0;
        state_d  = in_last ? ST_SEND : ST_LOAD;
      end
      ST_LOAD: if (in_hs) begin
        if (len_q == LEN_MAX) begin
          ovf_d = 1'b1;
        end else begin
          wr_en = 1'b1;
          len_d = len_q + 1'b1;
        end
        rd_ptr_d = '0;
        if (in_last) state_d = ST_SEND;
      end
      ST_SEND: begin
        // Address runs one ahead of the byte currently on M.
        rd_addr  = AW'(rd_ptr_q + 1'b1);
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (rd_ptr_q == len_q - 1'b1) state_d = ST_WAIT;
      end
      ST_WAIT: if (hash_ready || tmo_hit) state_d = ST_DONE;
      ST_DONE: if (dig_hs) begin
        state_d = ST_IDLE;
        len_d   = '0;
        ovf_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      in_ready  <= 1'b0;
      M_valid   <= 1'b0;
      C_in      <= '0;
      dig_valid <= 1'b0;
      dig_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      in_ready  <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
      M_valid   <= (state_d == ST_SEND);
      C_in      <= (state_d == ST_SEND) ? {{(HASH_LEN_W-LW){1'b0}}, len_d} : '0;
      dig_valid <= (state_d == ST_DONE);
      busy      <= (state_d != ST_IDLE);
      if (state_q == ST_WAIT) begin
        if (hash_ready)   dig_data <= digest;
        else if (tmo_hit) dig_data <= '0;
      end
    end
  end

`ifdef HASH_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_q;

  // tmo_cnt holds the number of WAIT cycles already spent before the current one.
  assign tmo_hit = (state_q == ST_WAIT) && (tmo_cnt == TW'(TIMEOUT - 1));
  assign err_tmo = tmo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state_q == ST_WAIT) ? tmo_cnt + 1'b1 : '0;
      if (tmo_hit && !hash_ready) tmo_q <= 1'b1;
      else if (dig_hs)            tmo_q <= 1'b0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed and randomized bench for hash_msg_feeder; expected bursts, lengths and
// flags come from the message queue and the truncate-to-DEPTH rule.
module tb_hash_msg_feeder;
  import hash_pkg::*;

  localparam int DEPTH = 16;
  localparam int DIG_W = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [7:0]            in_data = '0;
  logic                  in_last = 1'b0;
  logic                  M_valid;
  logic [7:0]            M;
  logic [HASH_LEN_W-1:0] C_in;
  logic                  hash_ready = 1'b0;
  logic [DIG_W-1:0]      digest = '0;
  logic                  dig_valid;
  logic                  dig_ready = 1'b0;
  logic [DIG_W-1:0]      dig_data;
  logic                  err_ovf;
  logic                  err_tmo;
  logic                  busy;
  feeder_state_t         fsm_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] msg[$];

  always #5 clk = ~clk;

  hash_msg_feeder #(.DEPTH(DEPTH), .DIG_W(DIG_W), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .M_valid    (M_valid),
    .M          (M),
    .C_in       (C_in),
    .hash_ready (hash_ready),
    .digest     (digest),
    .dig_valid  (dig_valid),
    .dig_ready  (dig_ready),
    .dig_data   (dig_data),
    .err_ovf    (err_ovf),
    .err_tmo    (err_tmo),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_m_valid"}, M_valid, 0);
    check({tag, "_m"}, M, 0);
    check({tag, "_c_in"}, C_in, 0);
    check({tag, "_dig_valid"}, dig_valid, 0);
    check({tag, "_dig_data"}, dig_data, 0);
    check({tag, "_err_ovf"}, err_ovf, 0);
    check({tag, "_err_tmo"}, err_tmo, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Presents every byte of msg, with random idle gaps of gap_pct percent.
  task automatic load_msg(input int gap_pct);
    for (int i = 0; i < msg.size(); i++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data  = msg[i];
      in_last  = (i == msg.size() - 1);
      for (int n = 0; n < 50 && !in_ready; n++) tick();
      if (!in_ready) check("in_ready_wait", in_ready, 1);
      check("m_valid_during_load", M_valid, 0);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  // Starts on the cycle after the in_last handshake.
  task automatic check_burst();
    int n;
    n = (msg.size() > DEPTH) ? DEPTH : msg.size();
    for (int k = 0; k < n; k++) begin
      check("m_valid", M_valid, 1);
      check("m_byte", M, msg[k]);
      check("c_in", C_in, 64'(n));
      tick();
    end
    check("m_valid_after", M_valid, 0);
    check("c_in_after", C_in, 0);
    check("m_after", M, 0);
    check("busy_wait", busy, 1);
    check("in_ready_wait_state", in_ready, 0);
  endtask

  task automatic finish_msg(input logic [DIG_W-1:0] dig, input int wait_cycles,
                            input int hold, input logic exp_ovf);
    for (int c = 0; c < wait_cycles; c++) begin
      check("dig_valid_early", dig_valid, 0);
      tick();
    end
    hash_ready = 1'b1;
    digest     = dig;
    tick();
    hash_ready = 1'b0;
    digest     = DIG_W'($urandom);
    check("dig_valid", dig_valid, 1);
    check("dig_data", dig_data, 64'(dig));
    check("err_ovf", err_ovf, 64'(exp_ovf));
    check("err_tmo", err_tmo, 0);
    for (int c = 0; c < hold; c++) begin
      tick();
      check("hold_dig_valid", dig_valid, 1);
      check("hold_dig_data", dig_data, 64'(dig));
      check("hold_in_ready", in_ready, 0);
      check("hold_err_ovf", err_ovf, 64'(exp_ovf));
    end
    dig_ready = 1'b1;
    tick();
    dig_ready = 1'b0;
    check("dig_valid_clear", dig_valid, 0);
    check("in_ready_after", in_ready, 1);
    check("busy_after", busy, 0);
    check("err_ovf_clear", err_ovf, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check("in_ready_post_reset", in_ready, 1);
    check("busy_post_reset", busy, 0);
    check("state_idle", fsm_state, ST_IDLE);

    // Single-byte message
    msg = {8'h5A};
    load_msg(0);
    check_burst();
    finish_msg(32'hDEADBEEF, 2, 0, 1'b0);

    // 15 bytes with in_valid toggling
    msg.delete();
    for (int i = 0; i < 15; i++) msg.push_back(8'(i));
    load_msg(50);
    check_burst();
    finish_msg(32'h1234_5678, 0, 1, 1'b0);

    // Overflow: 20 bytes, truncated to DEPTH
    msg.delete();
    for (int i = 0; i < 20; i++) msg.push_back(8'($urandom));
    load_msg(20);
    check_burst();
    finish_msg(32'hCAFE_F00D, 3, 0, 1'b1);

    // Exactly DEPTH bytes is not an overflow
    msg.delete();
    for (int i = 0; i < DEPTH; i++) msg.push_back(8'($urandom));
    load_msg(0);
    check_burst();
    finish_msg(32'h0BAD_CAFE, 1, 0, 1'b0);

    // Back-pressure for 10 cycles, then immediate next message
    msg = {8'h11, 8'h22};
    load_msg(0);
    check_burst();
    finish_msg(32'hA5A5_5A5A, 1, 10, 1'b0);
    msg = {8'h33, 8'h44, 8'h55};
    load_msg(0);
    check_burst();
    finish_msg(32'h0F0F_F0F0, 0, 0, 1'b0);

    // Reset on the 5th SEND cycle
    msg.delete();
    for (int i = 0; i < 8; i++) msg.push_back(8'(8'hA0 + i));
    load_msg(0);
    for (int k = 0; k < 4; k++) begin
      check("pre_reset_m", M, msg[k]);
      tick();
    end
    check("pre_reset_m_valid", M_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("mid_reset");
    tick();
    check("in_ready_after_abort", in_ready, 1);
    msg = {8'h01, 8'h02, 8'h03};
    load_msg(0);
    check_burst();
    finish_msg(32'h3333_0003, 2, 0, 1'b0);

    // Randomized messages; stray hash_ready pulses while idle must be ignored
    for (int t = 0; t < 10; t++) begin
      hash_ready = 1'b1;
      digest     = DIG_W'($urandom);
      tick();
      hash_ready = 1'b0;
      check("stray_hash_dig_valid", dig_valid, 0);
      check("stray_hash_busy", busy, 0);
      msg.delete();
      for (int i = 0; i < $urandom_range(1, 22); i++) msg.push_back(8'($urandom));
      load_msg(30);
      check_burst();
      finish_msg(DIG_W'($urandom), $urandom_range(0, 5), $urandom_range(0, 4),
                 msg.size() > DEPTH);
    end

`ifdef HASH_FEEDER_TIMEOUT_EN
    // Timeout after 8 WAIT cycles, then hash_ready on the terminal cycle
    msg = {8'h77, 8'h88};
    load_msg(0);
    check_burst();
    for (int c = 1; c <= 8; c++) begin
      check("tmo_dig_valid_early", dig_valid, 0);
      tick();
    end
    check("tmo_dig_valid", dig_valid, 1);
    check("tmo_err_tmo", err_tmo, 1);
    check("tmo_dig_data", dig_data, 0);
    dig_ready = 1'b1;
    tick();
    dig_ready = 1'b0;
    check("tmo_err_clear", err_tmo, 0);
    load_msg(0);
    check_burst();
    for (int c = 1; c <= 7; c++) tick();
    hash_ready = 1'b1;
    digest     = 32'h8888_0008;
    tick();
    hash_ready = 1'b0;
    check("tmo_race_dig_valid", dig_valid, 1);
    check("tmo_race_err_tmo", err_tmo, 0);
    check("tmo_race_dig_data", dig_data, 64'h8888_0008);
    dig_ready = 1'b1;
    tick();
    dig_ready = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_msg_feeder.md
# hash_msg_feeder

Initiator-side driver for the `fullHash` core's message interface. It accepts a byte message from an upstream valid/ready stream into an internal buffer. It replays the message into the hash core as a contiguous `M_valid` burst with the byte count on `C_in`, waits for `hash_ready`, then presents the captured digest downstream until it is consumed. It sits between the host/bus byte source and `fullHash`, one instance per hash core.

## Interface
- `DEPTH`, 16, message buffer depth in bytes (power of 2, 2..256); maximum message length
- `DIG_W`, 32, digest width
- `TIMEOUT`, 1024, cycles allowed in WAIT for `hash_ready` (used only with the timeout macro)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream byte valid
- `in_ready`  out  1  feeder accepts byte
- `in_data`  in  8  message byte
- `in_last`  in  1  marks final byte of message
- `M_valid`  out  1  byte valid to hash core
- `M`  out  8  message byte to hash core
- `C_in`  out  64  message length in bytes, zero-extended
- `hash_ready`  in  1  one-cycle digest-valid pulse from hash core
- `digest`  in  DIG_W  digest from hash core
- `dig_valid`  out  1  captured digest available
- `dig_ready`  in  1  downstream consumes digest
- `dig_data`  out  DIG_W  captured digest
- `err_ovf`  out  1  message exceeded `DEPTH`; valid with `dig_valid`
- `err_tmo`  out  1  hash core timed out (macro only; tied 0 otherwise)
- `busy`  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, LOAD, SEND, WAIT, DONE.
- IDLE: `in_ready`=1. The first accepted byte is written to `buf[0]`, `len`=1, and the FSM goes to LOAD. If `in_last` is also set, it goes directly to SEND.
- LOAD: `in_ready`=1. Each handshake writes `buf[len]` and increments `len`. A handshake with `in_last` moves to SEND.
- Overflow: once `len`==`DEPTH`, further bytes are still accepted (`in_ready`=1) but discarded, and `err_ovf` is set. The message is truncated to `DEPTH` bytes. `in_last` ends LOAD as normal.
- SEND: `M_valid`=1 for exactly `len` consecutive cycles, driving `M`=`buf[k]` on cycle k. `C_in`=`len` for all of SEND. `in_ready`=0. After the last byte the FSM goes to WAIT.
- Outside SEND: `M_valid`=0, `M`=0, `C_in`=0.
- WAIT: `hash_ready` is sampled. When it is high, the FSM latches `digest` into `dig_data` and goes to DONE. `hash_ready` in any other state is ignored.
- DONE: `dig_valid`=1. `dig_data`, `err_ovf` and `err_tmo` are held stable until `dig_ready`. On the handshake the FSM clears the flags and `len` and returns to IDLE.
- `len` counter width is clog2(DEPTH)+1; no wrap-around.

## Timing
- Reset values: `in_ready`=0, `M_valid`=0, `M`=0, `C_in`=0, `dig_valid`=0, `dig_data`=0, `err_ovf`=0, `err_tmo`=0, `busy`=0. The FSM enters IDLE, so `in_ready`=1 on the first cycle after `rst` falls.
- Reset mid-operation aborts immediately: the burst stops at the next edge and the buffer contents are treated as invalid.
- Timing from the last input handshake:
  - First `M_valid` cycle follows one cycle after the `in_last` handshake.
  - Burst length equals `len` cycles with no gaps.
  - WAIT begins the cycle after the last byte.
- `dig_valid` rises one cycle after `hash_ready`.
- `dig_valid` and `dig_ready` high in the same cycle completes the handshake. The FSM is in IDLE and `in_ready`=1 on the next cycle.
- The feeder is not pipelined: no new message is accepted from LOAD-complete until DONE is consumed.
- All outputs are registered.

## Configuration
- `HASH_FEEDER_TIMEOUT_EN` defined: a WAIT cycle counter runs.
  - Reaching `TIMEOUT` cycles without `hash_ready` sets `err_tmo` and moves to DONE with `dig_data`=0.
  - A `hash_ready` arriving on the same cycle as the terminal count wins: the digest is captured and `err_tmo`=0.
- Not defined: WAIT blocks indefinitely, no counter is synthesised, and `err_tmo` is tied to 0.

## Structure
- Package `hash_pkg` holds:
  - FSM state enum `feeder_state_t`
  - `HASH_LEN_W`=64 and the default `DIG_W`
  - shared with `fullHash` and its bench
- The buffer is a natural sub-module: `hash_msg_buf`.
  - Single-port write, single-port read, `DEPTH`×8.
  - Combinational read address, registered read data.
  - The SEND read address leads the output by one cycle.

## Test plan
- Single-byte message: one byte 0x5A with `in_last` → one `M_valid` cycle, `M`=0x5A, `C_in`=1. A `hash_ready` pulse with `digest`=0xDEADBEEF → `dig_valid`, `dig_data`=0xDEADBEEF.
- 15-byte message 0x00..0x0E → 15 contiguous `M_valid` cycles, `M` incrementing 0..14, `C_in`=15 throughout; no gaps even with `in_valid` toggling during LOAD.
- Overflow: 20 bytes with `DEPTH`=16 → burst of 16 bytes with `C_in`=16. `err_ovf`=1 with `dig_valid`, and clears after the `dig_ready` handshake.
- Back-pressure: `dig_ready` held low 10 cycles → `dig_data` stable and `in_ready`=0 throughout. Release → IDLE, and the next message is accepted the following cycle.
- `rst` pulsed on the 5th SEND cycle → `M_valid`=0 the next cycle and all outputs at reset values. A new 3-byte message then completes normally.
- With `HASH_FEEDER_TIMEOUT_EN` and `TIMEOUT`=8, no `hash_ready` → `dig_valid` with `err_tmo`=1 and `dig_data`=0 after 8 WAIT cycles. A repeat with `hash_ready` on cycle 8 → digest captured and `err_tmo`=0.
